// File: rtl/float_result_buffer.sv
// rtl/float_result_buffer.sv - sanitising writeback FIFO with sticky FP exception flags
module float_result_buffer #(
  parameter int DEPTH = 4,
  parameter int RD_W  = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_alu_op,
  input  logic [RD_W-1:0]          in_rd,
  input  logic [31:0]              in_result,
  input  logic                     in_cmp,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [RD_W-1:0]          out_rd,
  output logic [31:0]              out_data,
  output logic                     out_is_cmp,
  output logic [2:0]               flags,
  input  logic                     flags_clear,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]    mem_data [DEPTH];
  logic [RD_W-1:0] mem_rd  [DEPTH];
  logic           mem_cmp  [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;

  logic        op_cmp;
  logic        op_fp;
  logic        accept;
  logic        push;
  logic        pop;
  logic [31:0] san_data;
  logic [2:0]  set_bits;
  logic [7:0]  exp_f;
  logic [22:0] man_f;

  assign exp_f     = in_result[30:23];
  assign man_f     = in_result[22:0];
  assign op_cmp    = (in_alu_op == 4'd6) || (in_alu_op == 4'd7) || (in_alu_op == 4'd8);
  assign op_fp     = (in_alu_op >= 4'd1) && (in_alu_op <= 4'd5);

  assign in_ready  = (count != FULL);
  assign out_valid = (count != '0);
  assign accept    = in_valid && in_ready;
  assign push      = accept && (op_cmp || op_fp);
  assign pop       = out_valid && out_ready;

  // Zero exponent flushes before the all-ones check; only a nonzero mantissa counts as underflow.
  always_comb begin
    san_data = in_result;
    set_bits = 3'b000;
    if (op_cmp) begin
      san_data = {31'b0, in_cmp};
    end else if (op_fp) begin
      if (exp_f == 8'h00) begin
        san_data    = 32'h0000_0000;
        set_bits[0] = (man_f != 23'b0);
      end else if (exp_f == 8'hFF) begin
        san_data    = {in_result[31], 8'hFF, 23'b0};
        set_bits[1] = 1'b1;
      end
    end else begin
      set_bits[2] = 1'b1;
    end
    if (!accept) set_bits = 3'b000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      flags  <= 3'b000;
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_rd[i]   <= '0;
        mem_cmp[i]  <= 1'b0;
      end
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= san_data;
        mem_rd[wr_ptr]   <= in_rd;
        mem_cmp[wr_ptr]  <= op_cmp;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A new event wins over a same-cycle clear.
      flags <= (flags_clear ? 3'b000 : flags) | set_bits;
    end
  end

  assign out_rd     = mem_rd[rd_ptr];
  assign out_data   = mem_data[rd_ptr];
  assign out_is_cmp = mem_cmp[rd_ptr];

endmodule

// File: tb/tb_float_result_buffer.sv
// tb/tb_float_result_buffer.sv - directed self-checking bench for float_result_buffer
module tb_float_result_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_alu_op;
  logic [4:0]  in_rd;
  logic [31:0] in_result;
  logic        in_cmp;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_rd;
  logic [31:0] out_data;
  logic        out_is_cmp;
  logic [2:0]  flags;
  logic        flags_clear;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_err = 0;

  float_result_buffer #(.DEPTH(4), .RD_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_alu_op(in_alu_op),
    .in_rd(in_rd), .in_result(in_result), .in_cmp(in_cmp),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
    .out_data(out_data), .out_is_cmp(out_is_cmp),
    .flags(flags), .flags_clear(flags_clear), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [4:0] rd,
                       input logic [31:0] res, input logic c);
    in_valid  = v;
    in_alu_op = op;
    in_rd     = rd;
    in_result = res;
    in_cmp    = c;
  endtask

  task automatic head(input string tag, input logic [4:0] rd, input logic [31:0] d, input logic c);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_rd"}, 32'(out_rd), 32'(rd));
    chk({tag, "_data"}, out_data, d);
    chk({tag, "_is_cmp"}, 32'(out_is_cmp), 32'(c));
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b0; flags_clear = 1'b0;
    drive(1'b1, 4'd1, 5'd9, 32'h3F80_0000, 1'b0);
    #1;
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_rd", 32'(out_rd), 32'd0);
    chk("rst_out_is_cmp", 32'(out_is_cmp), 32'd0);
    rst = 1'b0;

    // Pass-through ordering with out_ready held high
    out_ready = 1'b1;
    drive(1'b1, 4'd1, 5'd1, 32'h3F80_0000, 1'b0);
    tick();
    head("pt1", 5'd1, 32'h3F80_0000, 1'b0);
    chk("pt1_count", 32'(count), 32'd1);
    drive(1'b1, 4'd3, 5'd2, 32'h4040_0000, 1'b0);
    tick();
    head("pt2", 5'd2, 32'h4040_0000, 1'b0);
    chk("pt2_count", 32'(count), 32'd1);
    drive(1'b1, 4'd8, 5'd3, 32'h1234_5678, 1'b1);
    tick();
    head("pt3", 5'd3, 32'h0000_0001, 1'b1);
    drive(1'b0, 4'd1, 5'd0, 32'h0, 1'b0);
    tick();
    chk("pt_drained_valid", 32'(out_valid), 32'd0);
    chk("pt_drained_count", 32'(count), 32'd0);

    // Sanitisation
    drive(1'b1, 4'd1, 5'd4, 32'h8000_0000, 1'b0);
    tick();
    head("negzero", 5'd4, 32'h0000_0000, 1'b0);
    chk("negzero_flags", 32'(flags), 32'd0);
    drive(1'b1, 4'd2, 5'd5, 32'h0000_0001, 1'b0);
    tick();
    head("subnorm", 5'd5, 32'h0000_0000, 1'b0);
    chk("subnorm_flags", 32'(flags), 32'b001);
    drive(1'b1, 4'd3, 5'd6, 32'hFFC0_0001, 1'b0);
    tick();
    head("nan", 5'd6, 32'hFF80_0000, 1'b0);
    chk("nan_flags", 32'(flags), 32'b011);
    drive(1'b1, 4'd5, 5'd7, 32'hBF80_0000, 1'b0);
    tick();
    head("normal", 5'd7, 32'hBF80_0000, 1'b0);
    drive(1'b1, 4'd6, 5'd8, 32'hFFFF_FFFF, 1'b0);
    tick();
    head("eq0", 5'd8, 32'h0000_0000, 1'b1);
    drive(1'b0, 4'd1, 5'd0, 32'h0, 1'b0);
    flags_clear = 1'b1;
    tick();
    flags_clear = 1'b0;
    chk("clear_flags", 32'(flags), 32'd0);
    chk("clear_count", 32'(count), 32'd0);

    // Full / backpressure
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'd1, 5'(10 + i), 32'h4100_0000 + 32'(i), 1'b0);
      chk("bp_in_ready_pre", 32'(in_ready), 32'd1);
      tick();
    end
    chk("bp_count_full", 32'(count), 32'd4);
    chk("bp_in_ready_full", 32'(in_ready), 32'd0);
    drive(1'b1, 4'd1, 5'd14, 32'h4100_0004, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("bp_stall_count", 32'(count), 32'd4);
      head("bp_stall_head", 5'd10, 32'h4100_0000, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_after_pop_count", 32'(count), 32'd3);
    chk("bp_after_pop_ready", 32'(in_ready), 32'd1);
    tick();
    chk("bp_fifth_count", 32'(count), 32'd4);
    drive(1'b0, 4'd1, 5'd0, 32'h0, 1'b0);
    out_ready = 1'b1;
    for (int j = 11; j <= 14; j++) begin
      head("bp_drain", 5'(j), 32'h4100_0000 + 32'(j - 10), 1'b0);
      tick();
    end
    chk("bp_drained_count", 32'(count), 32'd0);

    // Simultaneous push/pop across pointer wrap
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 4'd4, 5'(16 + k), 32'h4200_0000 + 32'(k), 1'b0);
      tick();
    end
    out_ready = 1'b1;
    for (int k = 2; k < 10; k++) begin
      drive(1'b1, 4'd4, 5'(16 + k), 32'h4200_0000 + 32'(k), 1'b0);
      head("wrap_head", 5'(14 + k), 32'h4200_0000 + 32'(k - 2), 1'b0);
      tick();
      chk("wrap_count", 32'(count), 32'd2);
    end
    drive(1'b0, 4'd1, 5'd0, 32'h0, 1'b0);
    for (int k = 8; k < 10; k++) begin
      head("wrap_tail", 5'(16 + k), 32'h4200_0000 + 32'(k), 1'b0);
      tick();
    end
    chk("wrap_drained_count", 32'(count), 32'd0);

    // Illegal opcode, then clear together with an overflow event
    out_ready = 1'b0;
    drive(1'b1, 4'd0, 5'd3, 32'h3F80_0000, 1'b0);
    tick();
    chk("ill_count", 32'(count), 32'd0);
    chk("ill_flags", 32'(flags), 32'b100);
    chk("ill_out_valid", 32'(out_valid), 32'd0);
    drive(1'b1, 4'd4, 5'd7, 32'h7F80_0000, 1'b0);
    flags_clear = 1'b1;
    tick();
    flags_clear = 1'b0;
    chk("clr_of_flags", 32'(flags), 32'b010);
    chk("clr_of_count", 32'(count), 32'd1);
    head("inf", 5'd7, 32'h7F80_0000, 1'b0);
    drive(1'b1, 4'd15, 5'd2, 32'h0, 1'b0);
    tick();
    chk("ill15_count", 32'(count), 32'd1);
    chk("ill15_flags", 32'(flags), 32'b110);

    // Mid-stream reset discards queued entries
    drive(1'b1, 4'd1, 5'd1, 32'h3F80_0000, 1'b0);
    tick();
    chk("pre_rst_count", 32'(count), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, 4'd1, 5'd0, 32'h0, 1'b0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", out_data, 32'd0);
    chk("mid_rst_flags", 32'(flags), 32'd0);
    tick();
    chk("post_rst_count", 32'(count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
